// File: rtl/fir_cfg_ctl_mc.sv
// fir_cfg_ctl_mc: routes one config stream per session to a selected FIR channel.
// Optional trailing checksum word is built when FIR_CFG_CHECKSUM_EN is defined.
module fir_cfg_ctl_mc #(
  parameter int DATA_W    = 16,
  parameter int MAX_ORDER = 256,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int IDX_W     = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              isConfig,
  input  logic [CH_W-1:0]   Ch_Sel,
  input  logic [IDX_W-1:0]  Order_In,
  input  logic              Data_Valid_In,
  input  logic [DATA_W-1:0] Data_Config_In,
  output logic              isConfigACK,
  output logic              isConfigDone,
  output logic              Cfg_Err,
  output logic [CH_W-1:0]   Cfg_Ch,
  output logic [NUM_CH-1:0] isConfigFIR_Out,
  output logic              Fir_Valid,
  output logic              Fir_Sym,
  output logic [DATA_W-1:0] Data_ConfigFIR_Out,
  output logic [NUM_CH-1:0] isConfigOUTSC_Out,
  output logic [DATA_W-1:0] Data_ConfigOUTSC_Out
);

  localparam int TmrW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] MaxOrd = IDX_W'(MAX_ORDER);
  localparam logic [CH_W:0] NumCh = (CH_W + 1)'(NUM_CH);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

  typedef enum logic [2:0] {
    Idle,
    Coef,
    Scale,
    Sym,
`ifdef FIR_CFG_CHECKSUM_EN
    Csum,
`endif
    Done
  } state_t;

  state_t state, stateD;

  logic [IDX_W-1:0]  cnt, cntD;
  logic [IDX_W-1:0]  order, orderD;
  logic [TmrW-1:0]   timer, timerD, tmrInc;
  logic              ackQ, ackD;
  logic              doneQ, doneD;
  logic              errQ, errD;
  logic [CH_W-1:0]   chQ, chD;
  logic [NUM_CH-1:0] firStbQ, firStbD;
  logic              firVldQ, firVldD;
  logic              firSymQ, firSymD;
  logic [DATA_W-1:0] firDatQ, firDatD;
  logic [NUM_CH-1:0] scStbQ, scStbD;
  logic [DATA_W-1:0] scDatQ, scDatD;
`ifdef FIR_CFG_CHECKSUM_EN
  logic [DATA_W-1:0] sum, sumD;
`endif

  logic              badReq, busy;
  logic [NUM_CH-1:0] reqHot, selHot;

  assign reqHot = NUM_CH'(1) << Ch_Sel;
  assign selHot = NUM_CH'(1) << chQ;
  assign badReq = (Order_In > MaxOrd) | ({1'b0, Ch_Sel} >= NumCh);
  assign busy   = (state != Idle) && (state != Done);
  assign tmrInc = timer + TmrW'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= Idle;
      cnt     <= '0;
      order   <= '0;
      timer   <= '0;
      ackQ    <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
      chQ     <= '0;
      firStbQ <= '0;
      firVldQ <= 1'b0;
      firSymQ <= 1'b0;
      firDatQ <= '0;
      scStbQ  <= '0;
      scDatQ  <= '0;
`ifdef FIR_CFG_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      state   <= stateD;
      cnt     <= cntD;
      order   <= orderD;
      timer   <= timerD;
      ackQ    <= ackD;
      doneQ   <= doneD;
      errQ    <= errD;
      chQ     <= chD;
      firStbQ <= firStbD;
      firVldQ <= firVldD;
      firSymQ <= firSymD;
      firDatQ <= firDatD;
      scStbQ  <= scStbD;
      scDatQ  <= scDatD;
`ifdef FIR_CFG_CHECKSUM_EN
      sum     <= sumD;
`endif
    end
  end

  always_comb begin
    stateD  = state;
    cntD    = cnt;
    orderD  = order;
    timerD  = timer;
    ackD    = ackQ;
    doneD   = 1'b0;
    errD    = 1'b0;
    chD     = chQ;
    firStbD = '0;
    firVldD = 1'b0;
    firSymD = 1'b0;
    firDatD = firDatQ;
    scStbD  = '0;
    scDatD  = scDatQ;
`ifdef FIR_CFG_CHECKSUM_EN
    sumD    = sum;
`endif
    unique case (state)
      Idle: begin
        if (isConfig) begin
          if (badReq) begin
            errD = 1'b1;
          end else begin
            chD     = Ch_Sel;
            orderD  = Order_In;
            ackD    = 1'b1;
            firStbD = reqHot;
            cntD    = '0;
            timerD  = '0;
            stateD  = Coef;
`ifdef FIR_CFG_CHECKSUM_EN
            sumD    = '0;
`endif
          end
        end
      end
      Coef: begin
        if (Data_Valid_In) begin
          firDatD = Data_Config_In;
          firVldD = 1'b1;
          cntD    = cnt + IDX_W'(1);
          if (cnt == order) stateD = Scale;
        end
      end
      Scale: begin
        if (Data_Valid_In) begin
          scDatD = Data_Config_In;
          scStbD = selHot;
          stateD = Sym;
        end
      end
      Sym: begin
        if (Data_Valid_In) begin
          firDatD = Data_Config_In;
          firVldD = 1'b1;
          firSymD = 1'b1;
`ifdef FIR_CFG_CHECKSUM_EN
          stateD  = Csum;
`else
          stateD  = Done;
          doneD   = 1'b1;
          ackD    = 1'b0;
`endif
        end
      end
`ifdef FIR_CFG_CHECKSUM_EN
      Csum: begin
        if (Data_Valid_In) begin
          ackD = 1'b0;
          if (Data_Config_In == sum) begin
            doneD  = 1'b1;
            stateD = Done;
          end else begin
            errD   = 1'b1;
            stateD = Idle;
          end
        end
      end
`endif
      Done: stateD = Idle;
      default: stateD = Idle;
    endcase
`ifdef FIR_CFG_CHECKSUM_EN
    // the checksum word itself is not part of the sum
    if (busy && Data_Valid_In && state != Csum)
      sumD = sum + Data_Config_In;
`endif
    if (busy) begin
      if (Data_Valid_In) begin
        timerD = '0;
      end else begin
        timerD = tmrInc;
        if (tmrInc == TmrMax) begin
          errD   = 1'b1;
          ackD   = 1'b0;
          stateD = Idle;
        end
      end
    end
  end

  assign isConfigACK          = ackQ;
  assign isConfigDone         = doneQ;
  assign Cfg_Err              = errQ;
  assign Cfg_Ch               = chQ;
  assign isConfigFIR_Out      = firStbQ;
  assign Fir_Valid            = firVldQ;
  assign Fir_Sym              = firSymQ;
  assign Data_ConfigFIR_Out   = firDatQ;
  assign isConfigOUTSC_Out    = scStbQ;
  assign Data_ConfigOUTSC_Out = scDatQ;

endmodule

// File: tb/tb_fir_cfg_ctl_mc.sv
// tb_fir_cfg_ctl_mc: directed bench for the multi-channel FIR config controller.
// Three channels and an 8-cycle timeout so channel range and stall paths are reachable.
module tb_fir_cfg_ctl_mc;
  localparam int DW  = 16;
  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int IW  = 10;
  localparam int TO  = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic isConfig = 1'b0;
  logic [CW-1:0] Ch_Sel = '0;
  logic [IW-1:0] Order_In = '0;
  logic Data_Valid_In = 1'b0;
  logic [DW-1:0] Data_Config_In = '0;
  logic isConfigACK, isConfigDone, Cfg_Err, Fir_Valid, Fir_Sym;
  logic [CW-1:0] Cfg_Ch;
  logic [NCH-1:0] isConfigFIR_Out, isConfigOUTSC_Out;
  logic [DW-1:0] Data_ConfigFIR_Out, Data_ConfigOUTSC_Out;

  fir_cfg_ctl_mc #(
    .DATA_W(DW), .MAX_ORDER(256), .NUM_CH(NCH),
    .CH_W(CW), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .isConfig(isConfig), .Ch_Sel(Ch_Sel), .Order_In(Order_In),
    .Data_Valid_In(Data_Valid_In), .Data_Config_In(Data_Config_In),
    .isConfigACK(isConfigACK), .isConfigDone(isConfigDone),
    .Cfg_Err(Cfg_Err), .Cfg_Ch(Cfg_Ch),
    .isConfigFIR_Out(isConfigFIR_Out), .Fir_Valid(Fir_Valid),
    .Fir_Sym(Fir_Sym), .Data_ConfigFIR_Out(Data_ConfigFIR_Out),
    .isConfigOUTSC_Out(isConfigOUTSC_Out),
    .Data_ConfigOUTSC_Out(Data_ConfigOUTSC_Out)
  );

  int nCmp = 0;
  int nBad = 0;
  int cyc = 0;
  int startCyc = 0;
  int doneCnt = 0, errCnt = 0;
  int doneCyc = 0, errCyc = 0, lastFirCyc = 0;
  logic [DW:0] firQ[$];
  logic [NCH-1:0] stbQ[$];
  logic [NCH+DW-1:0] scQ[$];
  logic [DW-1:0] coefV [0:7];

`ifdef FIR_CFG_CHECKSUM_EN
  localparam int CX = 1;
`else
  localparam int CX = 0;
`endif

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Fir_Valid) begin
      firQ.push_back({Fir_Sym, Data_ConfigFIR_Out});
      lastFirCyc <= cyc;
    end
    if (isConfigFIR_Out != '0) stbQ.push_back(isConfigFIR_Out);
    if (isConfigOUTSC_Out != '0)
      scQ.push_back({isConfigOUTSC_Out, Data_ConfigOUTSC_Out});
    if (isConfigDone) begin
      doneCnt <= doneCnt + 1;
      doneCyc <= cyc;
    end
    if (Cfg_Err) begin
      errCnt <= errCnt + 1;
      errCyc <= cyc;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clearq;
    firQ.delete();
    stbQ.delete();
    scQ.delete();
  endtask

  task automatic start(input logic [CW-1:0] ch, input logic [IW-1:0] n);
    isConfig = 1'b1;
    Ch_Sel = ch;
    Order_In = n;
    tick();
    isConfig = 1'b0;
    startCyc = cyc;
  endtask

  task automatic send(input logic [DW-1:0] w, input int gap);
    Data_Valid_In = 1'b0;
    repeat (gap) tick();
    Data_Valid_In = 1'b1;
    Data_Config_In = w;
    tick();
    Data_Valid_In = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int k;
    k = 0;
    while (doneCnt == d0 && errCnt == e0 && k < 40) begin
      tick();
      k++;
    end
    nCmp++;
    if (k >= 40) begin
      nBad++;
      $display("FAIL wait_end: got no Done/Err in 40 cycles, required one");
    end
    tick();
  endtask

  task automatic session(input logic [CW-1:0] ch, input int n,
                         input logic [DW-1:0] sc, input logic [DW-1:0] sy,
                         input int gap);
    int d0, e0;
`ifdef FIR_CFG_CHECKSUM_EN
    logic [DW-1:0] s;
    s = sc + sy;
`endif
    d0 = doneCnt;
    e0 = errCnt;
    start(ch, IW'(n));
    for (int i = 0; i <= n; i++) begin
      send(coefV[i], gap);
`ifdef FIR_CFG_CHECKSUM_EN
      s = s + coefV[i];
`endif
    end
    send(sc, gap);
    send(sy, gap);
`ifdef FIR_CFG_CHECKSUM_EN
    send(s, gap);
`endif
    wait_end(d0, e0);
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    repeat (3) tick();
    nCmp++;
    if ({isConfigACK, isConfigDone, Cfg_Err, Cfg_Ch, isConfigFIR_Out,
         Fir_Valid, Fir_Sym, Data_ConfigFIR_Out, isConfigOUTSC_Out,
         Data_ConfigOUTSC_Out} !== '0) begin
      nBad++;
      $display("FAIL reset_outs: got nonzero outputs, required all 0");
    end
    nRST = 1'b1;
    tick();
    nCmp++;
    if (isConfigACK !== 1'b0 || Fir_Valid !== 1'b0) begin
      nBad++;
      $display("FAIL reset_idle: ack=%b vld=%b required 0 0",
               isConfigACK, Fir_Valid);
    end
  endtask

  task automatic test_basic;
    logic [DW:0] expQ [0:4];
    int d0, e0;
    expQ = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h10001};
    clearq();
    d0 = doneCnt;
    e0 = errCnt;
    start(2'd2, 10'd3);
    nCmp++;
    if (isConfigFIR_Out !== 3'b100 || isConfigACK !== 1'b1) begin
      nBad++;
      $display("FAIL basic_start: stb=%b ack=%b required 100 1",
               isConfigFIR_Out, isConfigACK);
    end
    send(16'd1, 0);
    send(16'd2, 0);
    send(16'd3, 0);
    send(16'd4, 0);
    send(16'h0100, 0);
    nCmp++;
    if (isConfigACK !== 1'b1) begin
      nBad++;
      $display("FAIL basic_ack_sym: got %b required 1", isConfigACK);
    end
    send(16'd1, 0);
`ifdef FIR_CFG_CHECKSUM_EN
    send(16'h010B, 0);
`endif
    wait_end(d0, e0);
    nCmp++;
    if (firQ.size() != 5) begin
      nBad++;
      $display("FAIL basic_nfir: got %0d required 5", firQ.size());
    end
    for (int i = 0; i < 5; i++) begin
      nCmp++;
      if (firQ[i] !== expQ[i]) begin
        nBad++;
        $display("FAIL basic_fir%0d: got %h required %h", i, firQ[i], expQ[i]);
      end
    end
    nCmp++;
    if (stbQ.size() != 1 || stbQ[0] !== 3'b100) begin
      nBad++;
      $display("FAIL basic_firstb: got n=%0d first=%b required 1 x 100",
               stbQ.size(), stbQ[0]);
    end
    nCmp++;
    if (scQ.size() != 1 || scQ[0] !== {3'b100, 16'h0100}) begin
      nBad++;
      $display("FAIL basic_scale: got n=%0d %h required 1 x %h",
               scQ.size(), scQ[0], {3'b100, 16'h0100});
    end
    nCmp++;
    if (doneCnt - d0 != 1 || errCnt != e0) begin
      nBad++;
      $display("FAIL basic_done: got done=%0d err=%0d required 1 0",
               doneCnt - d0, errCnt - e0);
    end
    nCmp++;
    if (doneCyc - startCyc != 6 + CX) begin
      nBad++;
      $display("FAIL basic_lat: got %0d required %0d",
               doneCyc - startCyc, 6 + CX);
    end
    nCmp++;
    if (isConfigACK !== 1'b0 || Cfg_Ch !== 2'd2) begin
      nBad++;
      $display("FAIL basic_after: ack=%b ch=%0d required 0 2",
               isConfigACK, Cfg_Ch);
    end
    nCmp++;
    if (Data_ConfigOUTSC_Out !== 16'h0100 || Data_ConfigFIR_Out !== 16'd1) begin
      nBad++;
      $display("FAIL basic_hold: sc=%h fir=%h required 0100 0001",
               Data_ConfigOUTSC_Out, Data_ConfigFIR_Out);
    end
  endtask

  task automatic test_gaps;
    int d0, e0;
    clearq();
    d0 = doneCnt;
    e0 = errCnt;
    session(2'd2, 3, 16'h0100, 16'd1, 1);
    nCmp++;
    if (firQ.size() != 5 || firQ[0] !== 17'h00001 || firQ[3] !== 17'h00004
        || firQ[4] !== 17'h10001) begin
      nBad++;
      $display("FAIL gaps_fir: n=%0d f0=%h f3=%h f4=%h required 5 00001 00004 10001",
               firQ.size(), firQ[0], firQ[3], firQ[4]);
    end
    nCmp++;
    if (doneCnt - d0 != 1 || errCnt != e0) begin
      nBad++;
      $display("FAIL gaps_done: done=%0d err=%0d required 1 0",
               doneCnt - d0, errCnt - e0);
    end
    nCmp++;
    if (doneCyc - startCyc != 12 + 2 * CX) begin
      nBad++;
      $display("FAIL gaps_lat: got %0d required %0d",
               doneCyc - startCyc, 12 + 2 * CX);
    end
  endtask

  task automatic test_range;
    int d0, e0;
    clearq();
    start(2'd1, 10'd257);
    nCmp++;
    if (Cfg_Err !== 1'b1 || isConfigACK !== 1'b0 || isConfigFIR_Out !== '0) begin
      nBad++;
      $display("FAIL range_order: err=%b ack=%b stb=%b required 1 0 000",
               Cfg_Err, isConfigACK, isConfigFIR_Out);
    end
    tick();
    nCmp++;
    if (Cfg_Err !== 1'b0 || isConfigACK !== 1'b0) begin
      nBad++;
      $display("FAIL range_pulse: err=%b ack=%b required 0 0",
               Cfg_Err, isConfigACK);
    end
    start(2'd3, 10'd2);
    nCmp++;
    if (Cfg_Err !== 1'b1 || isConfigACK !== 1'b0 || isConfigFIR_Out !== '0) begin
      nBad++;
      $display("FAIL range_ch: err=%b ack=%b stb=%b required 1 0 000",
               Cfg_Err, isConfigACK, isConfigFIR_Out);
    end
    tick();
    d0 = doneCnt;
    e0 = errCnt;
    start(2'd2, 10'd256);
    nCmp++;
    if (Cfg_Err !== 1'b0 || isConfigACK !== 1'b1 || isConfigFIR_Out !== 3'b100) begin
      nBad++;
      $display("FAIL range_max: err=%b ack=%b stb=%b required 0 1 100",
               Cfg_Err, isConfigACK, isConfigFIR_Out);
    end
    wait_end(d0, e0);
    nCmp++;
    if (scQ.size() != 0 || stbQ.size() != 1) begin
      nBad++;
      $display("FAIL range_strobes: sc=%0d fir=%0d required 0 1",
               scQ.size(), stbQ.size());
    end
  endtask

  task automatic test_timeout;
    int d0, e0, k;
    clearq();
    coefV[0] = 16'd1;
    coefV[1] = 16'd2;
    d0 = doneCnt;
    e0 = errCnt;
    session(2'd1, 1, 16'd5, 16'd0, TO - 1);
    nCmp++;
    if (doneCnt - d0 != 1 || errCnt != e0
        || doneCyc - startCyc != 4 * TO + CX * TO) begin
      nBad++;
      $display("FAIL tmo_edge: done=%0d err=%0d lat=%0d required 1 0 %0d",
               doneCnt - d0, errCnt - e0, doneCyc - startCyc, 4 * TO + CX * TO);
    end
    clearq();
    d0 = doneCnt;
    e0 = errCnt;
    start(2'd1, 10'd3);
    send(16'd1, 0);
    send(16'd2, 0);
    k = 0;
    while (errCnt == e0 && k < 40) begin
      tick();
      k++;
    end
    nCmp++;
    if (errCnt - e0 != 1 || errCyc - lastFirCyc != TO) begin
      nBad++;
      $display("FAIL tmo_err: n=%0d dist=%0d required 1 %0d",
               errCnt - e0, errCyc - lastFirCyc, TO);
    end
    nCmp++;
    if (isConfigACK !== 1'b0 || doneCnt != d0 || firQ.size() != 2) begin
      nBad++;
      $display("FAIL tmo_state: ack=%b done=%0d nfir=%0d required 0 0 2",
               isConfigACK, doneCnt - d0, firQ.size());
    end
    tick();
    clearq();
    coefV[0] = 16'd9;
    coefV[1] = 16'd10;
    d0 = doneCnt;
    session(2'd0, 1, 16'd3, 16'd0, 0);
    nCmp++;
    if (doneCnt - d0 != 1 || stbQ.size() != 1 || stbQ[0] !== 3'b001) begin
      nBad++;
      $display("FAIL tmo_next: done=%0d stb=%b required 1 001",
               doneCnt - d0, stbQ[0]);
    end
    nCmp++;
    if (firQ.size() != 3 || firQ[0] !== 17'h00009 || firQ[1] !== 17'h0000A
        || firQ[2] !== 17'h10000 || scQ[0] !== {3'b001, 16'd3}) begin
      nBad++;
      $display("FAIL tmo_next_data: n=%0d %h %h %h sc=%h required 3 00009 0000a 10000 %h",
               firQ.size(), firQ[0], firQ[1], firQ[2], scQ[0], {3'b001, 16'd3});
    end
    coefV = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
  endtask

  task automatic test_ignore_reset;
    int d0, e0;
    clearq();
    start(2'd1, 10'd4);
    send(16'd1, 0);
    isConfig = 1'b1;
    Ch_Sel = 2'd0;
    Order_In = 10'd0;
    tick();
    isConfig = 1'b0;
    nCmp++;
    if (Cfg_Ch !== 2'd1 || isConfigFIR_Out !== '0 || isConfigACK !== 1'b1) begin
      nBad++;
      $display("FAIL ign_req: ch=%0d stb=%b ack=%b required 1 000 1",
               Cfg_Ch, isConfigFIR_Out, isConfigACK);
    end
    send(16'd2, 0);
    d0 = doneCnt;
    e0 = errCnt;
    nRST = 1'b0;
    #1;
    nCmp++;
    if ({isConfigACK, isConfigDone, Cfg_Err, Cfg_Ch, isConfigFIR_Out,
         Fir_Valid, Fir_Sym, Data_ConfigFIR_Out, isConfigOUTSC_Out,
         Data_ConfigOUTSC_Out} !== '0) begin
      nBad++;
      $display("FAIL rst_mid: got nonzero outputs, required all 0");
    end
    tick();
    tick();
    nRST = 1'b1;
    repeat (2 * TO) tick();
    nCmp++;
    if (doneCnt != d0 || errCnt != e0 || isConfigACK !== 1'b0) begin
      nBad++;
      $display("FAIL rst_quiet: done=%0d err=%0d ack=%b required 0 0 0",
               doneCnt - d0, errCnt - e0, isConfigACK);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW:0] expQ [0:4];
    int d0;
    expQ = '{17'h00001, 17'h10000, 17'h00001, 17'h00002, 17'h10003};
    clearq();
    d0 = doneCnt;
    session(2'd0, 0, 16'd6, 16'd0, 0);
    session(2'd2, 1, 16'd7, 16'd3, 0);
    nCmp++;
    if (doneCnt - d0 != 2) begin
      nBad++;
      $display("FAIL b2b_done: got %0d required 2", doneCnt - d0);
    end
    nCmp++;
    if (firQ.size() != 5) begin
      nBad++;
      $display("FAIL b2b_nfir: got %0d required 5", firQ.size());
    end
    for (int i = 0; i < 5; i++) begin
      nCmp++;
      if (firQ[i] !== expQ[i]) begin
        nBad++;
        $display("FAIL b2b_fir%0d: got %h required %h", i, firQ[i], expQ[i]);
      end
    end
    nCmp++;
    if (stbQ.size() != 2 || stbQ[0] !== 3'b001 || stbQ[1] !== 3'b100) begin
      nBad++;
      $display("FAIL b2b_stb: n=%0d %b %b required 2 001 100",
               stbQ.size(), stbQ[0], stbQ[1]);
    end
    nCmp++;
    if (scQ.size() != 2 || scQ[0] !== {3'b001, 16'd6}
        || scQ[1] !== {3'b100, 16'd7}) begin
      nBad++;
      $display("FAIL b2b_sc: n=%0d %h %h required 2 %h %h",
               scQ.size(), scQ[0], scQ[1], {3'b001, 16'd6}, {3'b100, 16'd7});
    end
  endtask

`ifdef FIR_CFG_CHECKSUM_EN
  task automatic test_checksum;
    int d0, e0;
    d0 = doneCnt;
    e0 = errCnt;
    start(2'd0, 10'd0);
    send(16'd5, 0);
    send(16'd2, 0);
    send(16'd0, 0);
    send(16'd7, 0);
    wait_end(d0, e0);
    nCmp++;
    if (doneCnt - d0 != 1 || errCnt != e0 || isConfigACK !== 1'b0) begin
      nBad++;
      $display("FAIL csum_ok: done=%0d err=%0d ack=%b required 1 0 0",
               doneCnt - d0, errCnt - e0, isConfigACK);
    end
    d0 = doneCnt;
    e0 = errCnt;
    start(2'd0, 10'd0);
    send(16'd5, 0);
    send(16'd2, 0);
    send(16'd0, 0);
    send(16'd8, 0);
    wait_end(d0, e0);
    nCmp++;
    if (doneCnt != d0 || errCnt - e0 != 1 || isConfigACK !== 1'b0) begin
      nBad++;
      $display("FAIL csum_bad: done=%0d err=%0d ack=%b required 0 1 0",
               doneCnt - d0, errCnt - e0, isConfigACK);
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    coefV = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    test_reset();
    test_basic();
    test_gaps();
    test_range();
    test_timeout();
    test_ignore_reset();
    test_back_to_back();
`ifdef FIR_CFG_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/fir_cfg_ctl_mc.md
Name: fir_cfg_ctl_mc

Overview:
Multi-channel successor to the single-channel FIR configuration controller. It accepts one configuration stream per session from the host: a channel select, a runtime filter order, then the coefficient, scale and symmetry words. Words are distributed to the selected channel's FIR core and output-scaler over shared data buses, qualified by per-channel strobes. Adds valid-qualified input (gaps allowed), runtime order, order/channel range checking and a stall timeout.

Parameters:
DATA_W, 16, config word width
MAX_ORDER, 256, largest legal runtime filter order
NUM_CH, 4, number of FIR channels served (1..16)
CH_W, 2, width of channel select (>= clog2(NUM_CH), min 1)
IDX_W, 10, word counter width (must hold MAX_ORDER+1)
TIMEOUT, 1023, idle cycles tolerated mid-session before abort (>=1)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
isConfig  in  1  session start request, sampled in IDLE only
Ch_Sel  in  CH_W  target channel, sampled with isConfig
Order_In  in  IDX_W  filter order N, sampled with isConfig
Data_Valid_In  in  1  qualifies Data_Config_In
Data_Config_In  in  DATA_W  config word stream
isConfigACK  out  1  session busy/acknowledge level
isConfigDone  out  1  one-cycle pulse, session committed
Cfg_Err  out  1  one-cycle pulse, session rejected or aborted
Cfg_Ch  out  CH_W  latched channel of current/last session
isConfigFIR_Out  out  NUM_CH  one-hot one-cycle start strobe to FIR core
Fir_Valid  out  1  pulse, Data_ConfigFIR_Out holds a coef/sym word
Fir_Sym  out  1  pulse alongside Fir_Valid for the symmetry word
Data_ConfigFIR_Out  out  DATA_W  FIR config data bus
isConfigOUTSC_Out  out  NUM_CH  one-hot one-cycle scale strobe
Data_ConfigOUTSC_Out  out  DATA_W  scale value, held until next scale write

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-session drops the session; no Done or Err is emitted.
- Session word order: coef[0..N] (N+1 words), scale, sym (plus checksum when the optional feature is built). Consume only when Data_Valid_In=1.
- IDLE, isConfig=1:
  - Order_In>MAX_ORDER or Ch_Sel>=NUM_CH: Cfg_Err pulse next cycle, stay IDLE.
  - Otherwise: latch Cfg_Ch and N; set ACK=1; pulse isConfigFIR_Out[ch]; clear cnt and timer; go to COEF.
- COEF: each valid word is registered to Data_ConfigFIR_Out with a Fir_Valid pulse (latency 1); cnt++. The valid word with cnt==N moves to SCALE.
- SCALE: a valid word goes to Data_ConfigOUTSC_Out, with a one-cycle isConfigOUTSC_Out[ch] pulse in the same cycle; then SYM.
- SYM: a valid word goes to Data_ConfigFIR_Out with Fir_Valid and Fir_Sym pulses; then DONE.
- DONE (one cycle): isConfigDone pulse, ACK=0, then IDLE. A new isConfig is accepted on the cycle after return to IDLE.
- isConfig while not IDLE: ignored. Data_Valid_In in IDLE/DONE: ignored.
- Timeout: in COEF/SCALE/SYM the timer increments each cycle with Data_Valid_In=0 and clears on a valid word. On reaching TIMEOUT: Cfg_Err pulse, ACK=0, go to IDLE. Words already delivered are not retracted; the FIR core must not apply them without Done.
- N=0 is legal: exactly one coef word.
- Data buses hold their value between pulses. Only the selected channel's strobe bit ever asserts.

Optional Feature:
FIR_CFG_CHECKSUM_EN
- Defined: state CSUM follows SYM. A 16-bit running modular sum (DATA_W bits, wrap) of every word from coef[0] through sym is kept. The next valid word is compared with it: equal gives isConfigDone, unequal gives Cfg_Err. Either way ACK drops and the block returns to IDLE.
- Undefined: no CSUM state, no adder; Done follows SYM directly.

Test Plan:
1. Reset, then isConfig with Ch_Sel=2, N=3, words 1,2,3,4, scale 0x0100, sym 1, no gaps. Required: isConfigFIR_Out=4'b0100 for one cycle; 5 Fir_Valid pulses with data 1,2,3,4,1; Fir_Sym on the last; OUTSC strobe 4'b0100 with data 0x0100; Done pulse; ACK high from start through SYM.
2. Same session with Data_Valid_In toggling every other cycle. Required: identical data and order, Done later, no Err.
3. N=257 (MAX_ORDER=256), or Ch_Sel=3 with NUM_CH=3. Required: Cfg_Err pulse, ACK stays 0, no strobes.
4. Stall after 2 coef words with TIMEOUT=8. Required: Cfg_Err exactly 8 cycles after the last valid word, ACK=0, then a new session on Ch 0 completes.
5. isConfig asserted in COEF with Ch_Sel changed, then nRST pulsed mid-COEF. Required: request ignored, Cfg_Ch unchanged; after reset all outputs 0 and no Done/Err.
6. (FIR_CFG_CHECKSUM_EN) N=0, words 5, scale 2, sym 0. Checksum 7 gives Done; checksum 8 gives Cfg_Err.
